// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default receive-buffer geometry and the
// per-cycle FIFO operation encoding used by the receive buffer.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int UART_RX_FIFO_DEPTH   = 16;
    localparam int UART_RX_FIFO_ADDR_W  = $clog2(UART_RX_FIFO_DEPTH);

    // Encoding matches the {push, pop} bit pair so a plain cast selects the op.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: byte strobe from the UART receiver, pop/clear from the core,
// and the head byte plus status flags back to the core.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_RX_FIFO_ADDR_W
);

    logic [UART_DATA_W-1:0] wr_data;
    logic                   wr_valid;
    logic                   rd_en;
    logic                   ovf_clr;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   empty;
    logic                   full;
    logic [ADDR_W:0]        count;
    logic                   overflow;

    modport master (
        output wr_data, wr_valid, rd_en, ovf_clr,
        input  rd_data, empty, full, count, overflow
    );

    modport slave (
        input  wr_data, wr_valid, rd_en, ovf_clr,
        output rd_data, empty, full, count, overflow
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port, so it can
// map onto distributed RAM or plain registers.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = UART_RX_FIFO_ADDR_W,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; empty/count gate its validity, and a reset term
    // would block mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular first-word-fall-through FIFO with
// occupancy count, registered empty/full and a sticky overflow flag for dropped bytes.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = UART_RX_FIFO_ADDR_W
) (
    input logic             clk,
    input logic             rst,
    uart_rx_fifo_if.slave   bus
);

    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              push;
    logic              pop;
    logic              drop;
    fifo_op_e          op;

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign pop  = bus.rd_en && !empty;
    assign push = bus.wr_valid && (!full || pop);
    assign drop = bus.wr_valid && !push;
    assign op   = fifo_op_e'({push, pop});

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        unique case (op)
            OP_PUSH: count_nxt = count + (ADDR_W + 1)'(1);
            OP_POP:  count_nxt = count - (ADDR_W + 1)'(1);
            default: count_nxt = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == COUNT_MAX);
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (UART_DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

    assign bus.count    = count;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.overflow = overflow;

endmodule : uart_rx_fifo
